sram_arbiter: RTL and testbench

//   Shares the single asynchronous SRAM between two requesters: the CPU (ISDU-driven MAR/MDR path)
//   and the program loader / debug port. Arbitrates round-robin, sequences the active-low
//   CE/OE/WE/UB/LB strobes with parameterised wait cycles, registers read data and returns a
//   one-cycle ready pulse. Sits between the datapath memory interface and the SRAM pins.

---
 rtl/sram_arbiter.sv | 172 +++++++++++++++++
 tb/tb_sram_arbiter.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one asynchronous SRAM between the CPU and the loader/debug port.
// Sequences the active-low SRAM strobes with fixed wait counts and returns a one-cycle ready pulse.
module sram_arbiter #(
  parameter int unsigned ADDR_W  = 20,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned RD_WAIT = 2,
  parameter int unsigned WR_WAIT = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ldr_ready,
  output logic [ADDR_W-1:0] Mem_ADDR,
  output logic [DATA_W-1:0] Data_to_SRAM,
  input  logic [DATA_W-1:0] Data_from_SRAM,
  output logic              Mem_drive,
  output logic              Mem_CE,
  output logic              Mem_UB,
  output logic              Mem_LB,
  output logic              Mem_OE,
  output logic              Mem_WE
);

  localparam int unsigned MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int unsigned CNT_W    = $clog2(MAX_WAIT) + 1;
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD      = 3'd1,
    S_WR      = 3'd2,
    S_WR_HOLD = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LDR = 1'b1
  } owner_t;

  state_t           state;
  owner_t           owner;
  owner_t           last_grant;
  logic [CNT_W-1:0] cnt;
  logic             armed_cpu;
  logic             armed_ldr;

  logic             cpu_elig_c;
  logic             ldr_elig_c;
  logic             pick_ldr_c;

  // On a tie the requester that did not win last time is chosen
  always_comb begin
    cpu_elig_c = cpu_req & armed_cpu;
    ldr_elig_c = ldr_req & armed_ldr;
    pick_ldr_c = ldr_elig_c & (~cpu_elig_c | (last_grant == OWN_CPU));
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= S_IDLE;
      owner        <= OWN_CPU;
      last_grant   <= OWN_LDR;
      cnt          <= '0;
      armed_cpu    <= 1'b1;
      armed_ldr    <= 1'b1;
      cpu_rdata    <= '0;
      ldr_rdata    <= '0;
      cpu_ready    <= 1'b0;
      ldr_ready    <= 1'b0;
      Mem_ADDR     <= '0;
      Data_to_SRAM <= '0;
      Mem_drive    <= 1'b0;
      Mem_CE       <= 1'b1;
      Mem_UB       <= 1'b1;
      Mem_LB       <= 1'b1;
      Mem_OE       <= 1'b1;
      Mem_WE       <= 1'b1;
    end else begin
      cpu_ready <= 1'b0;
      ldr_ready <= 1'b0;
      // A requester must show one low req cycle after its ready before it is served again
      armed_cpu <= ~cpu_req | (armed_cpu & ~cpu_ready);
      armed_ldr <= ~ldr_req | (armed_ldr & ~ldr_ready);

      case (state)
        S_IDLE: begin
          if (cpu_elig_c | ldr_elig_c) begin
            owner        <= pick_ldr_c ? OWN_LDR : OWN_CPU;
            last_grant   <= pick_ldr_c ? OWN_LDR : OWN_CPU;
            Mem_ADDR     <= pick_ldr_c ? ldr_addr : cpu_addr;
            Data_to_SRAM <= pick_ldr_c ? ldr_wdata : cpu_wdata;
            cnt          <= '0;
            Mem_CE       <= 1'b0;
            Mem_UB       <= 1'b0;
            Mem_LB       <= 1'b0;
            if (pick_ldr_c ? ldr_we : cpu_we) begin
              state     <= S_WR;
              Mem_WE    <= 1'b0;
              Mem_drive <= 1'b1;
            end else begin
              state  <= S_RD;
              Mem_OE <= 1'b0;
            end
          end
        end

        S_RD: begin
          if (cnt == RD_LAST) begin
            if (owner == OWN_LDR) ldr_rdata <= Data_from_SRAM;
            else                  cpu_rdata <= Data_from_SRAM;
            cpu_ready <= (owner == OWN_CPU);
            ldr_ready <= (owner == OWN_LDR);
            Mem_CE    <= 1'b1;
            Mem_UB    <= 1'b1;
            Mem_LB    <= 1'b1;
            Mem_OE    <= 1'b1;
            state     <= S_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_WR: begin
          if (cnt == WR_LAST) begin
            Mem_WE <= 1'b1;
            state  <= S_WR_HOLD;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // Data and chip enable stay valid one cycle past the WE rising edge
        S_WR_HOLD: begin
          cpu_ready <= (owner == OWN_CPU);
          ldr_ready <= (owner == OWN_LDR);
          Mem_CE    <= 1'b1;
          Mem_UB    <= 1'b1;
          Mem_LB    <= 1'b1;
          Mem_drive <= 1'b0;
          state     <= S_DONE;
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state     <= S_IDLE;
          Mem_drive <= 1'b0;
          Mem_CE    <= 1'b1;
          Mem_UB    <= 1'b1;
          Mem_LB    <= 1'b1;
          Mem_OE    <= 1'b1;
          Mem_WE    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM model on the pins, memory scoreboard and round-robin expectations.
module tb_sram_arbiter;

  localparam int unsigned ADDR_W  = 20;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned RD_WAIT = 2;
  localparam int unsigned WR_WAIT = 2;
  localparam int RD_LAT = RD_WAIT + 1;
  localparam int WR_LAT = WR_WAIT + 2;

  logic              Clk;
  logic              Reset;
  logic              cpu_req, cpu_we, cpu_ready;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              ldr_req, ldr_we, ldr_ready;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata, ldr_rdata;
  logic [ADDR_W-1:0] Mem_ADDR;
  logic [DATA_W-1:0] Data_to_SRAM, Data_from_SRAM, sram_q;
  logic              Mem_drive, Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;

  int errors = 0;
  int checks = 0;

  bit [15:0] sram    [0:255];
  bit        sram_wr [0:255];
  bit [15:0] mod_mem [0:255];
  bit        mod_wr  [0:255];
  bit        last_owner;
  logic [15:0] exp_cpu, exp_ldr;

  sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)) dut (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_rdata(ldr_rdata), .ldr_ready(ldr_ready),
    .Mem_ADDR(Mem_ADDR), .Data_to_SRAM(Data_to_SRAM), .Data_from_SRAM(Data_from_SRAM),
    .Mem_drive(Mem_drive), .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB),
    .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Unwritten locations read back a recognisable address-derived pattern
  function automatic logic [15:0] dflt(input logic [7:0] a);
    return {a, a + 8'h22};
  endfunction

  assign sram_q = sram_wr[Mem_ADDR[7:0]] ? sram[Mem_ADDR[7:0]] : dflt(Mem_ADDR[7:0]);
  assign Data_from_SRAM = (!Mem_CE && !Mem_OE) ? sram_q : 16'hDEAD;

  always @(posedge Clk) begin
    if (!Mem_CE && !Mem_WE && Mem_drive) begin
      sram[Mem_ADDR[7:0]]    <= Data_to_SRAM;
      sram_wr[Mem_ADDR[7:0]] <= 1'b1;
    end
  end

  function automatic logic [15:0] model_read(input logic [19:0] a);
    return mod_wr[a[7:0]] ? mod_mem[a[7:0]] : dflt(a[7:0]);
  endfunction

  task automatic model_write(input logic [19:0] a, input logic [15:0] d);
    mod_mem[a[7:0]] = d;
    mod_wr[a[7:0]]  = 1'b1;
  endtask

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic drive(input bit ldr, input bit req, input bit we, input logic [19:0] a,
                       input logic [15:0] d);
    if (ldr) begin
      ldr_req = req; ldr_we = we; ldr_addr = a; ldr_wdata = d;
    end else begin
      cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    end
  endtask

  task automatic apply_reset();
    Reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 20'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 20'h0, 16'h0);
    step();
    step();
    Reset = 1'b0;
    step();
    exp_cpu = 16'h0;
    exp_ldr = 16'h0;
    last_owner = 1'b1;
  endtask

  // Runs one access from an idle arbiter and measures the pin activity it causes
  task automatic do_access(input bit ldr, input bit we, input logic [19:0] a,
                           input logic [15:0] d, output int lat, output int oe_n,
                           output int we_n, output int ce_n, output int drv_n,
                           output int rdy_n, output int bad_n);
    lat = -1; oe_n = 0; we_n = 0; ce_n = 0; drv_n = 0; rdy_n = 0; bad_n = 0;
    drive(ldr, 1'b1, we, a, d);
    for (int n = 1; n <= 10; n++) begin
      step();
      if (!Mem_OE) oe_n++;
      if (!Mem_WE) we_n++;
      if (!Mem_CE && !Mem_UB && !Mem_LB) ce_n++;
      if (Mem_drive) drv_n++;
      if (Mem_drive && !Mem_OE) bad_n++;
      if (ldr ? cpu_ready : ldr_ready) bad_n++;
      if (ldr ? ldr_ready : cpu_ready) begin
        rdy_n++;
        if (lat < 0) lat = n;
        drive(ldr, 1'b0, we, a, d);
      end
    end
    drive(ldr, 1'b0, 1'b0, a, d);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 20'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 20'h0, 16'h0);
    step();
    checks++;
    if ({Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Mem_drive} !== 6'b111110)
      $display("FAIL reset_strobes: got %b expected 111110",
               {Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Mem_drive});
    if ({Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Mem_drive} !== 6'b111110) errors++;
    checks++;
    if ({cpu_ready, ldr_ready, cpu_rdata, ldr_rdata} !== 34'h0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b%b cpu_rdata=%h ldr_rdata=%h expected zeros",
               cpu_ready, ldr_ready, cpu_rdata, ldr_rdata);
    end
    checks++;
    if ({Mem_ADDR, Data_to_SRAM} !== 36'h0) begin
      errors++;
      $display("FAIL reset_addr_data: got %h/%h expected 0/0", Mem_ADDR, Data_to_SRAM);
    end
    Reset = 1'b0;
    step();
    exp_cpu = 16'h0;
    exp_ldr = 16'h0;
    last_owner = 1'b1;
    checks++;
    if ({Mem_CE, Mem_OE, Mem_WE, cpu_ready, ldr_ready} !== 5'b11100) begin
      errors++;
      $display("FAIL idle_after_reset: got %b expected 11100",
               {Mem_CE, Mem_OE, Mem_WE, cpu_ready, ldr_ready});
    end
  endtask

  task automatic test_cpu_read();
    int lat, oe_n, we_n, ce_n, drv_n, rdy_n, bad_n;
    do_access(1'b0, 1'b0, 20'h00012, 16'h0, lat, oe_n, we_n, ce_n, drv_n, rdy_n, bad_n);
    exp_cpu = model_read(20'h00012);
    last_owner = 1'b0;
    checks++;
    if (lat !== RD_LAT) begin
      errors++; $display("FAIL rd_latency: got %0d expected %0d", lat, RD_LAT);
    end
    checks++;
    if (oe_n !== RD_WAIT || ce_n !== RD_WAIT || we_n !== 0 || drv_n !== 0) begin
      errors++;
      $display("FAIL rd_strobes: got oe=%0d ce=%0d we=%0d drv=%0d expected %0d %0d 0 0",
               oe_n, ce_n, we_n, drv_n, RD_WAIT, RD_WAIT);
    end
    checks++;
    if (rdy_n !== 1 || bad_n !== 0) begin
      errors++; $display("FAIL rd_ready_once: got rdy=%0d bad=%0d expected 1 0", rdy_n, bad_n);
    end
    checks++;
    if (cpu_rdata !== exp_cpu || exp_cpu !== 16'h1234) begin
      errors++; $display("FAIL rd_data: got %h expected %h", cpu_rdata, exp_cpu);
    end
    checks++;
    if (ldr_rdata !== 16'h0) begin
      errors++; $display("FAIL rd_other_rdata: got %h expected 0000", ldr_rdata);
    end
  endtask

  task automatic test_ldr_write();
    int lat, oe_n, we_n, ce_n, drv_n, rdy_n, bad_n;
    do_access(1'b1, 1'b1, 20'h00005, 16'hBEEF, lat, oe_n, we_n, ce_n, drv_n, rdy_n, bad_n);
    model_write(20'h00005, 16'hBEEF);
    last_owner = 1'b1;
    checks++;
    if (lat !== WR_LAT) begin
      errors++; $display("FAIL wr_latency: got %0d expected %0d", lat, WR_LAT);
    end
    checks++;
    if (we_n !== WR_WAIT || drv_n !== WR_WAIT + 1 || ce_n !== WR_WAIT + 1 || oe_n !== 0) begin
      errors++;
      $display("FAIL wr_strobes: got we=%0d drv=%0d ce=%0d oe=%0d expected %0d %0d %0d 0",
               we_n, drv_n, ce_n, oe_n, WR_WAIT, WR_WAIT + 1, WR_WAIT + 1);
    end
    checks++;
    if (rdy_n !== 1 || bad_n !== 0 || ldr_rdata !== exp_ldr) begin
      errors++;
      $display("FAIL wr_ready: got rdy=%0d bad=%0d ldr_rdata=%h expected 1 0 %h",
               rdy_n, bad_n, ldr_rdata, exp_ldr);
    end
    do_access(1'b0, 1'b0, 20'h00005, 16'h0, lat, oe_n, we_n, ce_n, drv_n, rdy_n, bad_n);
    exp_cpu = model_read(20'h00005);
    last_owner = 1'b0;
    checks++;
    if (cpu_rdata !== exp_cpu || lat !== RD_LAT) begin
      errors++;
      $display("FAIL wr_readback: got %h lat %0d expected %h lat %0d", cpu_rdata, lat, exp_cpu, RD_LAT);
    end
  endtask

  task automatic test_round_robin();
    bit order[$];
    logic [19:0] ca, la;
    int c_left, l_left;
    apply_reset();
    ca = 20'h10 + 20'($urandom_range(0, 3));
    la = 20'h20 + 20'($urandom_range(0, 3));
    c_left = 2;
    l_left = 2;
    drive(1'b0, 1'b1, 1'b0, ca, 16'h0);
    drive(1'b1, 1'b1, 1'b0, la, 16'h0);
    for (int n = 0; n < 60 && (c_left > 0 || l_left > 0); n++) begin
      step();
      checks++;
      if (cpu_ready && ldr_ready) begin
        errors++; $display("FAIL rr_both_ready: got 11 expected at most one");
      end
      if (cpu_ready) begin
        order.push_back(1'b0);
        exp_cpu = model_read(ca);
        checks++;
        if (cpu_rdata !== exp_cpu) begin
          errors++; $display("FAIL rr_cpu_data: got %h expected %h", cpu_rdata, exp_cpu);
        end
        c_left--;
        cpu_req = 1'b0;
      end else if (c_left > 0) begin
        cpu_req = 1'b1;
      end
      if (ldr_ready) begin
        order.push_back(1'b1);
        exp_ldr = model_read(la);
        checks++;
        if (ldr_rdata !== exp_ldr) begin
          errors++; $display("FAIL rr_ldr_data: got %h expected %h", ldr_rdata, exp_ldr);
        end
        l_left--;
        ldr_req = 1'b0;
      end else if (l_left > 0) begin
        ldr_req = 1'b1;
      end
    end
    cpu_req = 1'b0;
    ldr_req = 1'b0;
    step();
    checks++;
    if (order.size() !== 4) begin
      errors++; $display("FAIL rr_count: got %0d expected 4", order.size());
    end
    for (int k = 0; k < order.size(); k++) begin
      checks++;
      if (order[k] !== bit'(k % 2)) begin
        errors++; $display("FAIL rr_order[%0d]: got %0d expected %0d", k, order[k], k % 2);
      end
    end
    if (order.size() > 0) last_owner = order[order.size() - 1];
  endtask

  task automatic test_hold_req();
    int lat, rdy, ce_after, oe_n, we_n, ce_n, drv_n, bad_n;
    lat = -1; rdy = 0; ce_after = 0;
    drive(1'b0, 1'b1, 1'b0, 20'h00012, 16'h0);
    for (int n = 1; n <= 12; n++) begin
      step();
      if (cpu_ready) begin
        rdy++;
        if (lat < 0) lat = n;
      end
      if (n > RD_LAT && !Mem_CE) ce_after++;
    end
    exp_cpu = model_read(20'h00012);
    last_owner = 1'b0;
    checks++;
    if (rdy !== 1 || lat !== RD_LAT || ce_after !== 0) begin
      errors++;
      $display("FAIL hold_no_rearm: got rdy=%0d lat=%0d ce_after=%0d expected 1 %0d 0",
               rdy, lat, ce_after, RD_LAT);
    end
    cpu_req = 1'b0;
    step();
    do_access(1'b0, 1'b0, 20'h00012, 16'h0, lat, oe_n, we_n, ce_n, drv_n, rdy, bad_n);
    checks++;
    if (rdy !== 1 || lat !== RD_LAT || cpu_rdata !== exp_cpu) begin
      errors++;
      $display("FAIL hold_rearmed: got rdy=%0d lat=%0d data=%h expected 1 %0d %h",
               rdy, lat, cpu_rdata, RD_LAT, exp_cpu);
    end
  endtask

  task automatic test_reset_mid_write();
    int stray, lat, oe_n, we_n, ce_n, drv_n, rdy, bad_n;
    stray = 0;
    drive(1'b1, 1'b1, 1'b1, 20'h00040, 16'hCAFE);
    step();
    checks++;
    if (Mem_WE !== 1'b0 || Mem_drive !== 1'b1) begin
      errors++; $display("FAIL abort_started: got we=%b drv=%b expected 0 1", Mem_WE, Mem_drive);
    end
    Reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 20'h0, 16'h0);
    #1;
    checks++;
    if ({Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Mem_drive, ldr_ready} !== 7'b1111100) begin
      errors++;
      $display("FAIL abort_immediate: got %b expected 1111100",
               {Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Mem_drive, ldr_ready});
    end
    step();
    Reset = 1'b0;
    exp_cpu = 16'h0;
    exp_ldr = 16'h0;
    last_owner = 1'b1;
    for (int n = 0; n < 5; n++) begin
      step();
      if (cpu_ready || ldr_ready || !Mem_CE) stray++;
    end
    checks++;
    if (stray !== 0) begin
      errors++; $display("FAIL abort_no_ready: got %0d stray cycles expected 0", stray);
    end
    do_access(1'b0, 1'b0, 20'h00012, 16'h0, lat, oe_n, we_n, ce_n, drv_n, rdy, bad_n);
    exp_cpu = model_read(20'h00012);
    last_owner = 1'b0;
    checks++;
    if (lat !== RD_LAT || rdy !== 1 || cpu_rdata !== exp_cpu) begin
      errors++;
      $display("FAIL abort_recover: got lat=%0d rdy=%0d data=%h expected %0d 1 %h",
               lat, rdy, cpu_rdata, RD_LAT, exp_cpu);
    end
  endtask

  task automatic test_drop_after_grant();
    int lat, rdy, addr_bad, oe_n, we_n, ce_n, drv_n, bad_n;
    do_access(1'b1, 1'b1, 20'h00077, 16'h5A5A, lat, oe_n, we_n, ce_n, drv_n, rdy, bad_n);
    model_write(20'h00077, 16'h5A5A);
    last_owner = 1'b1;
    lat = -1; rdy = 0; addr_bad = 0;
    drive(1'b0, 1'b1, 1'b0, 20'h00077, 16'h0);
    for (int n = 1; n <= 10; n++) begin
      step();
      if (n == 1) drive(1'b0, 1'b0, 1'b0, 20'h00078, 16'h0);
      if (!Mem_OE && Mem_ADDR !== 20'h00077) addr_bad++;
      if (cpu_ready) begin
        rdy++;
        if (lat < 0) lat = n;
      end
    end
    exp_cpu = model_read(20'h00077);
    last_owner = 1'b0;
    checks++;
    if (lat !== RD_LAT || rdy !== 1 || addr_bad !== 0) begin
      errors++;
      $display("FAIL drop_completes: got lat=%0d rdy=%0d addr_bad=%0d expected %0d 1 0",
               lat, rdy, addr_bad, RD_LAT);
    end
    checks++;
    if (cpu_rdata !== exp_cpu) begin
      errors++; $display("FAIL drop_data: got %h expected %h", cpu_rdata, exp_cpu);
    end
  endtask

  // Random single and contending accesses checked against the memory scoreboard
  task automatic test_random();
    int mode;
    bit c_we, l_we, c_done, l_done, first, exp_first;
    logic [19:0] c_a, l_a;
    logic [15:0] c_d, l_d;
    apply_reset();
    for (int it = 0; it < 40; it++) begin
      mode = int'($urandom_range(0, 2));
      c_we = bit'($urandom % 2);
      l_we = bit'($urandom % 2);
      c_a = 20'h80 + 20'($urandom_range(0, 7));
      l_a = 20'h80 + 20'($urandom_range(0, 7));
      c_d = 16'($urandom);
      l_d = 16'($urandom);
      c_done = (mode == 1);
      l_done = (mode == 0);
      first = 1'b1;
      exp_first = (last_owner == 1'b0);
      drive(1'b0, !c_done, c_we, c_a, c_d);
      drive(1'b1, !l_done, l_we, l_a, l_d);
      for (int n = 1; n <= 30 && !(c_done && l_done); n++) begin
        step();
        if (cpu_ready) begin
          checks++;
          if ((mode == 2 && first && exp_first !== 1'b0) ||
              (mode == 0 && n !== (c_we ? WR_LAT : RD_LAT))) begin
            errors++; $display("FAIL rand_cpu_timing: it=%0d n=%0d mode=%0d", it, n, mode);
          end
          if (c_we) model_write(c_a, c_d);
          else exp_cpu = model_read(c_a);
          checks++;
          if (cpu_rdata !== exp_cpu || ldr_rdata !== exp_ldr || ldr_ready) begin
            errors++;
            $display("FAIL rand_cpu_data: it=%0d got %h/%h expected %h/%h",
                     it, cpu_rdata, ldr_rdata, exp_cpu, exp_ldr);
          end
          cpu_req = 1'b0; c_done = 1'b1; first = 1'b0; last_owner = 1'b0;
        end
        if (ldr_ready) begin
          checks++;
          if ((mode == 2 && first && exp_first !== 1'b1) ||
              (mode == 1 && n !== (l_we ? WR_LAT : RD_LAT))) begin
            errors++; $display("FAIL rand_ldr_timing: it=%0d n=%0d mode=%0d", it, n, mode);
          end
          if (l_we) model_write(l_a, l_d);
          else exp_ldr = model_read(l_a);
          checks++;
          if (ldr_rdata !== exp_ldr || cpu_rdata !== exp_cpu) begin
            errors++;
            $display("FAIL rand_ldr_data: it=%0d got %h/%h expected %h/%h",
                     it, ldr_rdata, cpu_rdata, exp_ldr, exp_cpu);
          end
          ldr_req = 1'b0; l_done = 1'b1; first = 1'b0; last_owner = 1'b1;
        end
      end
      checks++;
      if (!(c_done && l_done)) begin
        errors++; $display("FAIL rand_timeout: it=%0d got done=%b%b expected 11", it, c_done, l_done);
      end
      cpu_req = 1'b0;
      ldr_req = 1'b0;
      step();
    end
  endtask

  initial begin
    Reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 20'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 20'h0, 16'h0);
    exp_cpu = 16'h0;
    exp_ldr = 16'h0;
    last_owner = 1'b1;
    @(negedge Clk);
    test_reset();
    test_cpu_read();
    test_ldr_write();
    test_round_robin();
    test_hold_req();
    test_reset_mid_write();
    test_drop_after_grant();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
